// File: rtl/ms_delay_scheduler.sv
// ms_delay_scheduler
//   One millisecond timebase shared between N_REQ requesters. A round-robin
//   arbiter picks one pending requester, counts its requested number of
//   milliseconds (CLKS_PER_MS clocks each), then pulses that requester's done.
//
// Ports
//   clk         clock
//   reset       synchronous, active-low
//   req         level request per requester, held until done or abort
//   req_ms      per-requester delay in ms, slice i = [i*MS_W +: MS_W]
//   pause       freezes counting while high
//   grant       one-hot requester being served, 0 when idle
//   done        one-hot single-cycle completion pulse
//   busy        high whenever the scheduler is not idle
//   elapsed_ms  whole milliseconds elapsed for the current grant
//
// state | meaning
// IDLE  | no grant; arbitrating among pending requests
// COUNT | counting the granted requester's delay
// DONE  | one-cycle completion; done pulse and grant both held
module ms_delay_scheduler #(
  parameter int N_REQ       = 4,
  parameter int CLKS_PER_MS = 20000,
  parameter int MS_W        = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*MS_W-1:0]   req_ms,
  input  logic                    pause,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic [MS_W-1:0]         elapsed_ms
);

  localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_MS - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cyc_cnt;
  logic [MS_W-1:0] target;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;

  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [MS_W-1:0] win_ms;
  logic [PW-1:0]   ptr_next;
  logic [MS_W-1:0] elapsed_inc;

  // Round-robin scan starting at ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_valid && req[(int'(ptr) + k) % N_REQ]) begin
        win_valid = 1'b1;
        win_idx   = PW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign win_ms      = req_ms[win_idx*MS_W +: MS_W];
  assign ptr_next    = (int'(gidx) == N_REQ - 1) ? '0 : gidx + PW'(1);
  assign elapsed_inc = elapsed_ms + MS_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      elapsed_ms <= '0;
      cyc_cnt    <= '0;
      target     <= '0;
      ptr        <= '0;
      gidx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            gidx       <= win_idx;
            grant      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            target     <= win_ms;
            cyc_cnt    <= '0;
            elapsed_ms <= '0;
            busy       <= 1'b1;
            // A zero-length delay completes immediately with grant and done together.
            if (win_ms == '0) begin
              state <= DONE;
              done  <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          // Requester withdrawing its request is an abort and outranks pause.
          if (!req[gidx]) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_next;
          end else if (!pause) begin
            if (cyc_cnt == CYC_LAST) begin
              cyc_cnt    <= '0;
              elapsed_ms <= elapsed_inc;
              if (elapsed_inc == target) begin
                state <= DONE;
                done  <= grant;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= '0;
          grant      <= '0;
          busy       <= 1'b0;
          elapsed_ms <= '0;
          ptr        <= ptr_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_delay_scheduler.sv
// Testbench for ms_delay_scheduler (N_REQ=4, CLKS_PER_MS=3, MS_W=4).
// Directed table and hand sequences, then random stimulus against a
// reference model that tracks total counted cycles per grant.
module tb_ms_delay_scheduler;

  localparam int N = 4;
  localparam int C = 3;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*W-1:0] req_ms = '0;
  logic          pause = 1'b0;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          busy;
  logic [W-1:0]  elapsed_ms;

  ms_delay_scheduler #(.N_REQ(N), .CLKS_PER_MS(C), .MS_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_ms(req_ms), .pause(pause),
    .grant(grant), .done(done), .busy(busy), .elapsed_ms(elapsed_ms)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [15:0] ms;
    logic       ps;
    logic [3:0] e_grant;
    logic [3:0] e_done;
    logic       e_busy;
    logic [3:0] e_elapsed;
  } vec_t;

  vec_t vecs[12];

  // model state: ph 0=idle 1=counting 2=completing
  int m_ph = 0, m_g = 0, m_served = 0, m_target = 0, m_p = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic [3:0] e);
    chk({name, ".grant"}, 16'(grant), 16'(g));
    chk({name, ".done"}, 16'(done), 16'(d));
    chk({name, ".busy"}, 16'(busy), 16'(b));
    chk({name, ".elapsed"}, 16'(elapsed_ms), 16'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_ph = 0; m_p = 0; m_served = 0;
    end else begin
      case (m_ph)
        0: begin
          bit found;
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_p + k) % N;
            if (!found && req[i]) begin
              found    = 1'b1;
              m_g      = i;
              m_target = int'(req_ms[i*W +: W]);
              m_served = 0;
              m_ph     = (m_target == 0) ? 2 : 1;
            end
          end
        end
        1: begin
          if (!req[m_g]) begin
            m_ph = 0; m_p = (m_g + 1) % N;
          end else if (!pause) begin
            m_served++;
            if (m_served == m_target * C) m_ph = 2;
          end
        end
        default: begin
          m_ph = 0; m_p = (m_g + 1) % N;
        end
      endcase
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_g;
    logic [3:0] eg, ed;

    // Single 2 ms request on requester 1, then a zero-delay request on 2.
    vecs[0]  = '{1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 4'b0010, 16'h0020, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd0};
    vecs[2]  = '{1'b1, 4'b0010, 16'h0020, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd0};
    vecs[3]  = '{1'b1, 4'b0010, 16'h0020, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd0};
    vecs[4]  = '{1'b1, 4'b0010, 16'h0020, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd1};
    vecs[5]  = '{1'b1, 4'b0010, 16'h0020, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd1};
    vecs[6]  = '{1'b1, 4'b0010, 16'h0020, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd1};
    vecs[7]  = '{1'b1, 4'b0010, 16'h0020, 1'b0, 4'b0010, 4'b0010, 1'b1, 4'd2};
    vecs[8]  = '{1'b1, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vecs[9]  = '{1'b1, 4'b0100, 16'h0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'd0};
    vecs[10] = '{1'b1, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vecs[11] = '{1'b1, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0};

    for (int i = 0; i < 12; i++) begin
      reset = vecs[i].rst; req = vecs[i].rq; req_ms = vecs[i].ms; pause = vecs[i].ps;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_done,
              vecs[i].e_busy, vecs[i].e_elapsed);
    end

    // Abort: requester 0 with 5 ms, withdrawn 4 cycles after grant.
    req = 4'b0001; req_ms = 16'h0005;
    step();
    chk("abort.grant", 16'(grant), 16'h1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("abort.nodone", 16'(done), 16'h0);
    end
    chk("abort.elapsed", 16'(elapsed_ms), 16'd1);
    req = 4'b0000;
    step();
    chk("abort.grant_clr", 16'(grant), 16'h0);
    chk("abort.busy_clr", 16'(busy), 16'h0);
    chk("abort.done_none", 16'(done), 16'h0);
    repeat (3) begin
      step();
      chk("abort.idle_done", 16'(done), 16'h0);
    end
    req = 4'b0001; req_ms = 16'h0001;
    step();
    chk("abort.rewin", 16'(grant), 16'h1);
    step(); step();
    chk("abort.rewin_early", 16'(done), 16'h0);
    step();
    chk("abort.rewin_done", 16'(done), 16'h1);
    req = 4'b0000;
    step();
    chk("abort.rewin_idle", 16'(grant), 16'h0);

    // Reset returns outputs to 0 and pointer to 0; then round-robin 1 and 3.
    reset = 1'b0;
    step();
    chk_all("rst", 4'b0000, 4'b0000, 1'b0, 4'd0);
    reset = 1'b1; req = 4'b1010; req_ms = 16'h1111;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      step();
      chk("rr.grant", 16'(grant), 16'(exp_g));
      chk("rr.done_lo0", 16'(done), 16'h0);
      step();
      chk("rr.done_lo1", 16'(done), 16'h0);
      step();
      chk("rr.done_lo2", 16'(done), 16'h0);
      step();
      chk("rr.done", 16'(done), 16'(exp_g));
      chk("rr.grant_held", 16'(grant), 16'(exp_g));
      step();
      chk("rr.idle", 16'(grant), 16'h0);
      chk("rr.idle_busy", 16'(busy), 16'h0);
    end
    req = 4'b0000;
    step();

    // Pause: 2 ms on requester 0, pause held for 4 edges once elapsed is 1.
    req = 4'b0001; req_ms = 16'h0002;
    step();
    chk("pause.grant", 16'(grant), 16'h1);
    step(); step(); step();
    chk("pause.elapsed1", 16'(elapsed_ms), 16'd1);
    step();
    pause = 1'b1;
    repeat (4) begin
      step();
      chk("pause.frozen", 16'(elapsed_ms), 16'd1);
      chk("pause.nodone", 16'(done), 16'h0);
      chk("pause.busy", 16'(busy), 16'h1);
    end
    pause = 1'b0;
    step();
    chk("pause.early", 16'(done), 16'h0);
    step();
    chk("pause.done", 16'(done), 16'h1);
    chk("pause.elapsed2", 16'(elapsed_ms), 16'd2);
    req = 4'b0000;
    step();
    chk("pause.idle", 16'(busy), 16'h0);

    // Reset mid-COUNT while elapsed is 1.
    req = 4'b0100; req_ms = 16'h0300;
    step();
    chk("rstmid.grant", 16'(grant), 16'h4);
    step(); step(); step();
    chk("rstmid.elapsed", 16'(elapsed_ms), 16'd1);
    reset = 1'b0;
    step();
    chk_all("rstmid.clr", 4'b0000, 4'b0000, 1'b0, 4'd0);
    reset = 1'b1; req = 4'b1100; req_ms = 16'h3300;
    step();
    chk("rstmid.p0", 16'(grant), 16'h4);
    chk("rstmid.restart", 16'(elapsed_ms), 16'd0);
    step(); step();
    chk("rstmid.e0", 16'(elapsed_ms), 16'd0);
    step();
    chk("rstmid.e1", 16'(elapsed_ms), 16'd1);
    reset = 1'b0; req = 4'b0000;
    step();
    reset = 1'b1;

    // Random stimulus against the reference model (model starts fresh from reset).
    m_ph = 0; m_p = 0; m_served = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
      if (done != 0 && $urandom_range(0, 1) == 1) req = req & ~done;
      if ($urandom_range(0, 3) == 0)
        for (int b = 0; b < N; b++)
          req_ms[b*W +: W] = ($urandom_range(0, 15) == 0) ? 4'd5 : 4'($urandom_range(0, 3));
      pause = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      model_edge();
      #1;
      eg = (m_ph != 0) ? 4'(1 << m_g) : 4'b0000;
      ed = (m_ph == 2) ? 4'(1 << m_g) : 4'b0000;
      chk("rand.grant", 16'(grant), 16'(eg));
      chk("rand.done", 16'(done), 16'(ed));
      chk("rand.busy", 16'(busy), 16'(m_ph != 0));
      if (m_ph != 0 || !reset)
        chk("rand.elapsed", 16'(elapsed_ms), 16'(m_served / C));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ms_delay_scheduler.md
# ms_delay_scheduler

Shares one millisecond timebase between N_REQ requesters that each need a programmable delay. Each requester asks for a delay of M milliseconds. The block picks one requester at a time by round-robin, counts M × CLKS_PER_MS clock cycles, then pulses that requester's done line. It sits between the game/sequencing FSMs and replaces per-FSM millisecond timers with one arbitrated counter.

## Interface
- N_REQ, 4: number of requesters (≥2).
- CLKS_PER_MS, 20000: clock cycles per millisecond (≥1).
- MS_W, 12: width of each delay request, in ms.

- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- req  in  N_REQ  level request, one bit per requester; held high until done or abort.
- req_ms  in  N_REQ*MS_W  delay per requester; slice i is [i*MS_W +: MS_W].
- pause  in  1  freezes counting while high.
- grant  out  N_REQ  one-hot, registered; index of the requester being served; 0 when idle.
- done  out  N_REQ  one-hot one-cycle pulse, registered; delay complete.
- busy  out  1  high whenever state ≠ IDLE.
- elapsed_ms  out  MS_W  whole ms elapsed for the current grant.

## Operation
- States: IDLE, COUNT, DONE. Reset (reset=0 at a clk edge) forces:
  - state=IDLE, grant=0, done=0, busy=0, elapsed_ms=0;
  - cycle counter=0, rr pointer p=0.
  - Reset has priority over everything, including mid-COUNT.
- Arbitration (IDLE):
  - Winner g is the first set bit of req, scanning p, p+1, …, N_REQ-1, 0, …, p-1.
  - On the edge: grant<=onehot(g), target<=req_ms[g], cycle counter<=0, elapsed_ms<=0.
  - If target=0, state<=DONE; otherwise state<=COUNT.
  - With no req set, the block stays in IDLE.
- COUNT, evaluated in priority order:
  1. req[g]=0 is an abort: state<=IDLE, grant<=0, p<=(g+1) mod N_REQ, no done pulse. Abort beats pause.
  2. pause=1: hold all counters.
  3. Otherwise the cycle counter increments. When it equals CLKS_PER_MS-1:
     - cycle counter<=0 and elapsed_ms<=elapsed_ms+1.
     - If elapsed_ms+1 == target: state<=DONE and done<=onehot(g).
- DONE (lasts exactly one cycle):
  - done is high and grant is still held.
  - Next edge: state<=IDLE, done<=0, grant<=0, elapsed_ms<=0, p<=(g+1) mod N_REQ.
  - pause and req are ignored in DONE.
- Widths:
  - Cycle counter is max(1,$clog2(CLKS_PER_MS)) bits.
  - elapsed_ms is MS_W bits. It never wraps, because target ≤ 2^MS_W-1 and the count stops at target.
- req_ms is sampled only at grant; later changes to req_ms are ignored until the next grant.
- A requester still holding req in IDLE after its done is treated as a new request. Because p has advanced, other pending requesters win first.

## Timing
- Latency with req seen high before edge E0 (grant edge), delay M≥1, no pause:
  - grant and busy go high after E0.
  - done is high for exactly the one cycle following edge E0+M*CLKS_PER_MS.
  - grant and busy drop after E0+M*CLKS_PER_MS+1.
- With M=0: done and grant both rise after E0; everything clears after E0+1.
- Each pause-high cycle in COUNT delays done by exactly one cycle.
- Back-to-back grants: minimum one IDLE cycle between the DONE cycle and the next grant edge.
- Abort: req[g] low before edge A means grant=0 and busy=0 after A, with no done pulse at any time.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
Bench parameters: N_REQ=4, CLKS_PER_MS=3, MS_W=4.
- Single request: req=0010, req_ms[1]=2, grant edge E0.
  - Required: grant=0010 from E0; done=0010 for the single cycle after E0+6; grant=0 and busy=0 after E0+7; elapsed_ms reads 1 after E0+3.
- Round-robin: req=1010 held, all delays 1 ms, p=0.
  - Required: grants in order 0010, 1000, 0010, …; one done pulse per grant, 3 cycles after each grant edge.
- Abort: req=0001, delay 5; drop req[0] 4 cycles after grant.
  - Required: grant=0 and busy=0 on the next edge, no done pulse; next request with req=0001 wins (p=1 wraps to index 0).
- Zero delay: req=0100, req_ms[2]=0.
  - Required: grant=0100 and done=0100 in the same cycle right after the grant edge; busy is high for exactly one cycle.
- Pause: delay 2 with pause high for 4 cycles mid-COUNT.
  - Required: done arrives after E0+10 instead of E0+6; elapsed_ms frozen while paused.
- Reset mid-COUNT: reset=0 for one edge while elapsed_ms=1.
  - Required: all outputs 0 after that edge and p=0; a re-asserted req restarts from elapsed_ms=0.
